// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the multiply datapath.
//   - mult_state_t : multiplier FSM state encoding
//   - OP_MULT      : ALU opcode that selects the multiply command
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_WAIT = 2'd3
  } mult_state_t;

  localparam logic [3:0] OP_MULT = 4'b1111;

endpackage

// File: rtl/alu_mult_unit.sv
// Sequential unsigned shift-add multiplier for the ALU multiply command.
// One partial product is accumulated per clock; WIDTH iterations per multiply.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   ctrl_en  : start/hold level, held high for the whole multiply window
//   mult_en  : product register write enable, sampled on the last iteration
//   x, y     : multiplicand / multiplier, captured on the start edge
//   product  : registered 2*WIDTH-bit result
//   busy     : high while iterating
//   done     : one-cycle completion pulse
//   zf, hf   : product==0 / upper half of product non-zero (registered with product)
module alu_mult_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_en,
  input  logic               mult_en,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic               zf,
  output logic               hf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mult_state_t     state;
  mult_state_t     state_next;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc_sum;
  logic            last_iter;

  // Accumulator value after this cycle's conditional add; also the final result on the last iteration.
  assign acc_sum   = acc + (mplier[0] ? mcand : {PW{1'b0}});
  assign last_iter = (state == ST_RUN) && ctrl_en && (cnt == LAST_CNT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ctrl_en low in RUN aborts, WAIT enforces one multiply per ctrl_en window.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) state_next = ST_RUN;
        else         state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (!ctrl_en)              state_next = ST_IDLE;
        else if (cnt == LAST_CNT)  state_next = ST_DONE;
        else                       state_next = ST_RUN;
      end
      ST_DONE: begin
        if (ctrl_en) state_next = ST_WAIT;
        else         state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (ctrl_en) state_next = ST_WAIT;
        else         state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shift-add datapath: operand capture on start, one iteration per RUN edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= {PW{1'b0}};
      mplier <= {WIDTH{1'b0}};
      acc    <= {PW{1'b0}};
      cnt    <= {CW{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_en) begin
            mcand  <= {{WIDTH{1'b0}}, x};
            mplier <= y;
            acc    <= {PW{1'b0}};
            cnt    <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          if (ctrl_en) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: begin
          mcand  <= mcand;
          mplier <= mplier;
          acc    <= acc;
          cnt    <= cnt;
        end
      endcase
    end
  end

  // Result and flag registers, written only on a completed final iteration with mult_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= {PW{1'b0}};
      zf      <= 1'b1;
      hf      <= 1'b0;
    end else if (last_iter && mult_en) begin
      product <= acc_sum;
      zf      <= (acc_sum == {PW{1'b0}});
      hf      <= |acc_sum[PW-1:WIDTH];
    end
  end

  // Status outputs registered alongside the state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == ST_RUN);
      done <= (state_next == ST_DONE);
    end
  end

endmodule
